// File: rtl/clm_aes_host_ctrl_pkg.sv
// Shared definitions for the CLM AES host controller.
//   RAND_WORDS    : number of masking-randomness words fed to the core
//   CLM_LFSR_TAPS : Galois tap mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   host_state_t  : controller FSM states
//   lfsr_step     : one Galois LFSR step
package clm_aes_host_ctrl_pkg;

    localparam int unsigned RAND_WORDS    = 23;
    localparam logic [31:0] CLM_LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        StRefill,
        StIdle,
        StStart,
        StWait,
        StHoldOut,
        StErr
    } host_state_t;

    // Shift right; fold the taps back in when the bit shifted out was 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ CLM_LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/clm_rand_filler.sv
// Masking-randomness generator: a 32-bit Galois LFSR that fills RAND_WORDS
// words, one per cycle while i_run is high, taking the low W bits of each new
// LFSR value.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_run        : step the LFSR and write word[fill counter] this cycle
//   i_seed_load  : load i_seed (0 -> SEED_DEFAULT) and restart at word 0
//   i_seed       : seed value
//   o_done       : this cycle writes the last word
//   o_words      : the randomness words (index 0 written first)
module clm_rand_filler
    import clm_aes_host_ctrl_pkg::*;
#(
    parameter int unsigned W            = 12,
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_run,
    input  logic                          i_seed_load,
    input  logic [31:0]                   i_seed,
    output logic                          o_done,
    output logic [RAND_WORDS-1:0][W-1:0]  o_words
);

    localparam logic [4:0] LAST_IDX = 5'(RAND_WORDS - 1);

    logic [31:0]                  r_lfsr;
    logic [4:0]                   r_cnt;
    logic [RAND_WORDS-1:0][W-1:0] r_words;
    logic [31:0]                  w_lfsr_next;

    assign w_lfsr_next = lfsr_step(r_lfsr);
    assign o_done      = i_run && !i_seed_load && (r_cnt == LAST_IDX);
    assign o_words     = r_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr  <= SEED_DEFAULT;
            r_cnt   <= '0;
            r_words <= '0;
        end else if (i_seed_load) begin
            // An all-zero seed would lock the LFSR at zero.
            r_lfsr <= (i_seed == 32'd0) ? SEED_DEFAULT : i_seed;
            r_cnt  <= '0;
        end else if (i_run) begin
            r_lfsr         <= w_lfsr_next;
            r_words[r_cnt] <= w_lfsr_next[W-1:0];
            // Wrap so the next refill starts at word 0 without extra control.
            r_cnt          <= (r_cnt == LAST_IDX) ? 5'd0 : r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/clm_aes_host_ctrl.sv
// Initiator-side controller for the CLM AES core.
// Accepts (plaintext, key, p_det) over a valid/ready stream, holds them on the
// core inputs together with a fresh randomness vector, launches the core with
// a one-cycle core_drdy_i pulse, captures the ciphertext on core_drdy_o and
// returns it over a valid/ready stream. A fresh randomness vector is generated
// before every block; a wait-state timeout parks the controller in an error
// state until reset.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : input block handshake
//   in_plaintext/in_key/in_p_det : input block
//   out_valid/out_ready          : result handshake
//   out_ciphertext               : captured ciphertext
//   seed_valid/seed              : LFSR reseed (honoured in refill/idle only)
//   busy                         : controller not idle
//   timeout_err                  : sticky timeout flag
//   core_*                       : connections to the AES core
module clm_aes_host_ctrl
    import clm_aes_host_ctrl_pkg::*;
#(
    parameter int unsigned d              = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] SEED_DEFAULT   = 32'hACE1_2468
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [127:0]                    in_plaintext,
    input  logic [127:0]                    in_key,
    input  logic [d-1:0]                    in_p_det,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [127:0]                    out_ciphertext,
    input  logic                            seed_valid,
    input  logic [31:0]                     seed,
    output logic                            busy,
    output logic                            timeout_err,
    output logic                            core_drdy_i,
    output logic [127:0]                    core_plaintext,
    output logic [127:0]                    core_key,
    output logic [d-1:0]                    core_p_det,
    output logic [RAND_WORDS-1:0][8+d-1:0]  core_random_vect,
    input  logic                            core_drdy_o,
    input  logic [127:0]                    core_ciphertext
);

    localparam int unsigned W         = 8 + d;
    localparam int unsigned CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    host_state_t     r_state;
    logic            r_drdy_i;
    logic [127:0]    r_pt;
    logic [127:0]    r_key;
    logic [d-1:0]    r_pdet;
    logic [127:0]    r_out_ct;
    logic            r_out_valid;
    logic            r_timeout;
    logic [CW-1:0]   r_wait_cnt;

    logic            w_fill_run;
    logic            w_fill_done;
    logic            w_seed_load;

    assign w_fill_run  = (r_state == StRefill);
    assign w_seed_load = seed_valid && ((r_state == StRefill) || (r_state == StIdle));

    clm_rand_filler #(
        .W            (W),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_filler (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_fill_run),
        .i_seed_load (w_seed_load),
        .i_seed      (seed),
        .o_done      (w_fill_done),
        .o_words     (core_random_vect)
    );

    // A reseed in idle must win over a coincident block offer.
    assign in_ready       = (r_state == StIdle) && !seed_valid;
    assign busy           = (r_state != StIdle);
    assign out_valid      = r_out_valid;
    assign out_ciphertext = r_out_ct;
    assign timeout_err    = r_timeout;
    assign core_drdy_i    = r_drdy_i;
    assign core_plaintext = r_pt;
    assign core_key       = r_key;
    assign core_p_det     = r_pdet;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StRefill;
            r_drdy_i    <= 1'b0;
            r_pt        <= '0;
            r_key       <= '0;
            r_pdet      <= '0;
            r_out_ct    <= '0;
            r_out_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                StRefill: begin
                    // A reseed here is handled inside the filler (restart at word 0).
                    if (w_fill_done) begin
                        r_state <= StIdle;
                    end
                end
                StIdle: begin
                    if (w_seed_load) begin
                        r_state <= StRefill;
                    end else if (in_valid) begin
                        r_pt     <= in_plaintext;
                        r_key    <= in_key;
                        r_pdet   <= in_p_det;
                        r_drdy_i <= 1'b1;
                        r_state  <= StStart;
                    end
                end
                StStart: begin
                    r_drdy_i   <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= StWait;
                end
                StWait: begin
                    r_wait_cnt <= r_wait_cnt + CW'(1);
                    // Completion takes priority over a timeout on the same cycle.
                    if (core_drdy_o) begin
                        r_out_ct    <= core_ciphertext;
                        r_out_valid <= 1'b1;
                        r_state     <= StHoldOut;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= StErr;
                    end
                end
                StHoldOut: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StRefill;
                    end
                end
                StErr: begin
                    r_state <= StErr;
                end
                default: begin
                    r_state <= StErr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clm_aes_host_ctrl.sv
// Directed bench for clm_aes_host_ctrl: table of blocks run through a
// behavioural core model, plus hand sequences for reseed, spurious done,
// mid-operation reset and timeout (second instance with a short timeout).
module tb_clm_aes_host_ctrl;
    import clm_aes_host_ctrl_pkg::*;

    localparam int unsigned D        = 4;
    localparam int unsigned W        = 8 + D;
    localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

    localparam logic [127:0] AES_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef logic [RAND_WORDS-1:0][W-1:0] rv_t;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [D-1:0] pdet;
        int unsigned  lat;
        int unsigned  hold;
        logic [127:0] ct;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_plaintext;
    logic [127:0]  in_key;
    logic [D-1:0]  in_p_det;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_ciphertext;
    logic          seed_valid;
    logic [31:0]   seed;
    logic          busy;
    logic          timeout_err;
    logic          core_drdy_i;
    logic [127:0]  core_plaintext;
    logic [127:0]  core_key;
    logic [D-1:0]  core_p_det;
    rv_t           core_random_vect;
    logic          core_drdy_o;
    logic [127:0]  core_ciphertext;

    // Short-timeout instance whose core never answers.
    logic          rst_to;
    logic          to_in_valid;
    logic          to_in_ready;
    logic          to_out_valid;
    logic [127:0]  to_out_ct;
    logic          to_busy;
    logic          to_timeout_err;
    logic          to_core_drdy_i;
    logic [127:0]  to_core_pt;
    logic [127:0]  to_core_key;
    logic [D-1:0]  to_core_pdet;
    rv_t           to_core_rv;
    logic          to_zero_bit = 1'b0;
    logic [127:0]  to_zero_ct = '0;

    always #5 clk = ~clk;

    clm_aes_host_ctrl #(
        .d              (D),
        .TIMEOUT_CYCLES (1024),
        .SEED_DEFAULT   (SEED_DEF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_plaintext     (in_plaintext),
        .in_key           (in_key),
        .in_p_det         (in_p_det),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_ciphertext   (out_ciphertext),
        .seed_valid       (seed_valid),
        .seed             (seed),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .core_drdy_i      (core_drdy_i),
        .core_plaintext   (core_plaintext),
        .core_key         (core_key),
        .core_p_det       (core_p_det),
        .core_random_vect (core_random_vect),
        .core_drdy_o      (core_drdy_o),
        .core_ciphertext  (core_ciphertext)
    );

    clm_aes_host_ctrl #(
        .d              (D),
        .TIMEOUT_CYCLES (16),
        .SEED_DEFAULT   (SEED_DEF)
    ) dut_to (
        .clk              (clk),
        .rst              (rst_to),
        .in_valid         (to_in_valid),
        .in_ready         (to_in_ready),
        .in_plaintext     (in_plaintext),
        .in_key           (in_key),
        .in_p_det         (in_p_det),
        .out_valid        (to_out_valid),
        .out_ready        (out_ready),
        .out_ciphertext   (to_out_ct),
        .seed_valid       (seed_valid),
        .seed             (seed),
        .busy             (to_busy),
        .timeout_err      (to_timeout_err),
        .core_drdy_i      (to_core_drdy_i),
        .core_plaintext   (to_core_pt),
        .core_key         (to_core_key),
        .core_p_det       (to_core_pdet),
        .core_random_vect (to_core_rv),
        .core_drdy_o      (to_zero_bit),
        .core_ciphertext  (to_zero_ct)
    );

    // Behavioural core: drdy_o comes m_lat cycles after the drdy_i cycle.
    int unsigned  m_lat;
    logic         m_busy;
    int unsigned  m_cnt;
    logic         m_drdy;
    logic [127:0] m_ct;
    logic         spur;

    assign core_drdy_o     = m_drdy | spur;
    assign core_ciphertext = spur ? 128'hdead_beef_dead_beef_dead_beef_dead_beef : m_ct;

    function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
        return (pt == AES_PT && key == AES_KEY) ? AES_CT : (~pt ^ key);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_drdy <= 1'b0;
            m_ct   <= '0;
        end else begin
            m_drdy <= 1'b0;
            if (core_drdy_i) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
            end else if (m_busy) begin
                if (m_cnt == m_lat - 1) begin
                    m_drdy <= 1'b1;
                    m_ct   <= model_ct(core_plaintext, core_key);
                    m_busy <= 1'b0;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_lfsr;
    rv_t         exp_rv;
    rv_t         rv_boot;

    function automatic logic [31:0] tb_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic model_refill();
        for (int k = 0; k < RAND_WORDS; k++) begin
            m_lfsr    = tb_step(m_lfsr);
            exp_rv[k] = m_lfsr[W-1:0];
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rv(input string name, input rv_t act, input rv_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until in_ready, bounded.
    task automatic wait_ready(input string name, input int start_n, input int exp_n);
        int n;
        n = start_n;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk_n(name, n, exp_n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd0);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out_ct"}, out_ciphertext, 128'd0);
        chk({tag, "_timeout"}, 128'(timeout_err), 128'd0);
        chk({tag, "_drdy_i"}, 128'(core_drdy_i), 128'd0);
        chk({tag, "_core_pt"}, core_plaintext, 128'd0);
        chk({tag, "_core_key"}, core_key, 128'd0);
        chk({tag, "_core_pdet"}, 128'(core_p_det), 128'd0);
        chk_rv({tag, "_core_rv"}, core_random_vect, '0);
        chk({tag, "_busy"}, 128'(busy), 128'd1);
    endtask

    task automatic run_block(input vec_t v);
        int n;
        int dr;
        m_lat = v.lat;
        chk("blk_in_ready", 128'(in_ready), 128'd1);
        in_valid     = 1'b1;
        in_plaintext = v.pt;
        in_key       = v.key;
        in_p_det     = v.pdet;
        tick();
        // Scramble the inputs to prove the controller holds its own copy.
        in_valid     = 1'b0;
        in_plaintext = ~v.pt;
        in_key       = ~v.key;
        in_p_det     = ~v.pdet;
        dr = core_drdy_i ? 1 : 0;
        n  = 0;
        while (!out_valid && n < int'(v.lat) + 10) begin
            chk("hold_pt", core_plaintext, v.pt);
            chk("hold_key", core_key, v.key);
            chk("hold_pdet", 128'(core_p_det), 128'(v.pdet));
            chk_rv("hold_rv", core_random_vect, exp_rv);
            tick();
            n++;
            if (core_drdy_i) dr++;
        end
        chk_n("latency", n, int'(v.lat) + 1);
        chk_n("drdy_i_pulses", dr, 1);
        chk("ciphertext", out_ciphertext, v.ct);
        for (int i = 0; i < int'(v.hold); i++) begin
            tick();
            chk("stall_valid", 128'(out_valid), 128'd1);
            chk("stall_ct", out_ciphertext, v.ct);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 128'(out_valid), 128'd0);
        model_refill();
        wait_ready("refill_after_out", 1, 24);
        chk_rv("refill_rv", core_random_vect, exp_rv);
    endtask

    vec_t vecs [4];

    initial begin
        int n;
        vecs[0] = '{pt: AES_PT, key: AES_KEY, pdet: 4'h3, lat: 20, hold: 0, ct: AES_CT};
        vecs[1] = '{pt: 128'h0123456789abcdef_fedcba9876543210, key: 128'h0, pdet: 4'h9,
                    lat: 40, hold: 10, ct: 128'hfedcba9876543210_0123456789abcdef};
        vecs[2] = '{pt: {16{8'hff}}, key: 128'h1, pdet: 4'hf, lat: 2, hold: 3, ct: 128'h1};
        vecs[3] = '{pt: {16{8'ha5}}, key: {16{8'h0f}}, pdet: 4'h1, lat: 5, hold: 1,
                    ct: {16{8'h55}}};

        rst          = 1'b1;
        rst_to       = 1'b1;
        in_valid     = 1'b0;
        to_in_valid  = 1'b0;
        in_plaintext = '0;
        in_key       = '0;
        in_p_det     = '0;
        out_ready    = 1'b0;
        seed_valid   = 1'b0;
        seed         = '0;
        spur         = 1'b0;
        m_lat        = 2;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        // Release between edges; the refill takes 23 edges.
        #2;
        rst    = 1'b0;
        rst_to = 1'b0;
        m_lfsr = SEED_DEF;
        model_refill();
        rv_boot = exp_rv;
        wait_ready("boot_refill", 0, 23);
        chk_rv("boot_rv", core_random_vect, exp_rv);
        chk("boot_rv_word0", 128'(core_random_vect[0]), 128'h234);
        chk("boot_busy", 128'(busy), 128'd0);

        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i]);
        end

        // Spurious done in idle.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_idle_busy", 128'(busy), 128'd0);
        chk("spur_idle_ready", 128'(in_ready), 128'd1);
        chk("spur_idle_valid", 128'(out_valid), 128'd0);
        chk("spur_idle_ct", out_ciphertext, {16{8'h55}});
        tick();
        chk("spur_idle_busy2", 128'(busy), 128'd0);

        // Spurious done while holding a result.
        m_lat        = 3;
        in_valid     = 1'b1;
        in_plaintext = 128'h0;
        in_key       = 128'hcafe;
        in_p_det     = 4'h6;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk_n("spur_hold_latency", n, 4);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_hold_valid", 128'(out_valid), 128'd1);
        chk("spur_hold_ct", out_ciphertext, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_3501);
        tick();
        chk("spur_hold_valid2", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_refill();
        wait_ready("spur_hold_refill", 1, 24);
        chk_rv("spur_hold_rv", core_random_vect, exp_rv);

        // Zero seed coinciding with a block offer: seed wins.
        in_valid     = 1'b1;
        in_plaintext = 128'h1234_5678;
        seed_valid   = 1'b1;
        seed         = 32'd0;
        #1;
        chk("seed_blocks_ready", 128'(in_ready), 128'd0);
        tick();
        seed_valid = 1'b0;
        in_valid   = 1'b0;
        chk("seed_busy", 128'(busy), 128'd1);
        chk("seed_no_launch", 128'(core_drdy_i), 128'd0);
        chk("seed_pt_kept", core_plaintext, 128'h0);
        chk("seed_key_kept", core_key, 128'hcafe);
        m_lfsr = SEED_DEF;
        model_refill();
        wait_ready("seed_refill", 0, 23);
        chk_rv("seed_rv", core_random_vect, exp_rv);
        chk("seed_rv_word0", 128'(core_random_vect[0]), 128'h234);

        // Asynchronous reset mid-wait.
        m_lat        = 40;
        in_valid     = 1'b1;
        in_plaintext = 128'h7777;
        in_key       = 128'h8888;
        in_p_det     = 4'h5;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("midwait_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("midwait_rst");
        #2;
        rst    = 1'b0;
        m_lfsr = SEED_DEF;
        model_refill();
        wait_ready("midwait_refill", 0, 23);
        chk_rv("midwait_rv", core_random_vect, exp_rv);
        run_block(vecs[0]);

        // Timeout on the short-timeout instance.
        in_plaintext = 128'h4242;
        in_key       = 128'h2424;
        in_p_det     = 4'ha;
        chk("to_ready", 128'(to_in_ready), 128'd1);
        to_in_valid = 1'b1;
        tick();
        to_in_valid = 1'b0;
        repeat (16) tick();
        chk("to_not_yet", 128'(to_timeout_err), 128'd0);
        tick();
        chk("to_set", 128'(to_timeout_err), 128'd1);
        to_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("to_err_ready", 128'(to_in_ready), 128'd0);
            chk("to_err_busy", 128'(to_busy), 128'd1);
            chk("to_err_drdy", 128'(to_core_drdy_i), 128'd0);
            chk("to_err_sticky", 128'(to_timeout_err), 128'd1);
        end
        to_in_valid = 1'b0;
        chk("to_err_valid", 128'(to_out_valid), 128'd0);
        chk("to_err_ct", to_out_ct, 128'd0);
        chk("to_err_pt", to_core_pt, 128'h4242);
        chk("to_err_key", to_core_key, 128'h2424);
        chk("to_err_pdet", 128'(to_core_pdet), 128'ha);
        chk_rv("to_err_rv", to_core_rv, rv_boot);
        rst_to = 1'b1;
        #1;
        chk("to_rst_clears", 128'(to_timeout_err), 128'd0);
        rst_to = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clm_aes_host_ctrl.md
Name: clm_aes_host_ctrl

Overview:
Initiator-side controller for the CLM AES core's basic inouts interface (plaintext, key, drdy_i, drdy_o, ciphertext), plus its p_det and 23-word random vector inputs. It accepts blocks over a valid/ready stream and launches the core with a one-cycle drdy_i pulse. It keeps all core inputs stable for the whole encryption, captures the ciphertext, and returns it over a valid/ready stream. Between blocks it refills a fresh masking-randomness vector from an internal LFSR and watches the core with a timeout.

Parameters:
d, 4, redundancy bits per red_poly_t word (word width W = 8+d; legal d 1..24)
TIMEOUT_CYCLES, 1024, maximum WAIT-state cycles before declaring timeout
SEED_DEFAULT, 32'hACE1_2468, LFSR value after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  block offered
in_ready  out  1  block accepted when in_valid & in_ready
in_plaintext  in  128  plaintext, core byte layout
in_key  in  128  key, core byte layout
in_p_det  in  p_det_t  reduction-polynomial selector for this block
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_ciphertext  out  128  captured ciphertext
seed_valid  in  1  load new LFSR seed
seed  in  32  seed value; 0 is replaced by SEED_DEFAULT
busy  out  1  state not IDLE
timeout_err  out  1  sticky timeout flag
core_drdy_i  out  1  start pulse to core
core_plaintext  out  128  held plaintext
core_key  out  128  held key
core_p_det  out  p_det_t  held p_det
core_random_vect  out  red_poly_t[0:22]  held randomness
core_drdy_o  in  1  core done
core_ciphertext  in  128  core result

Behaviour:
- States: REFILL, IDLE, START, WAIT, HOLD_OUT, ERR.
- Reset values: state REFILL, fill counter 0, LFSR = SEED_DEFAULT, all core_* data outputs 0, core_drdy_i 0, in_ready 0, out_valid 0, out_ciphertext 0, timeout_err 0, wait counter 0.
- REFILL: each cycle the LFSR steps once. LFSR is 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), shifting right and XORing the taps when bit0=1. Word k = fill counter gets the new LFSR bits [W-1:0].
  - Takes 23 cycles (k = 0..22), then IDLE.
  - core_random_vect changes only in REFILL.
- IDLE: in_ready=1. On handshake, register in_plaintext/in_key/in_p_det into the core_* outputs and go to START.
- START: core_drdy_i=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT: wait counter increments each cycle.
  - core_drdy_o=1: capture core_ciphertext into out_ciphertext and go to HOLD_OUT.
  - Counter == TIMEOUT_CYCLES-1 without drdy_o: set timeout_err and go to ERR.
  - drdy_o on the timeout cycle: completion wins.
- HOLD_OUT: out_valid=1, out_ciphertext stable. On out_ready, go to REFILL with fill counter 0. Latency from launch to out_valid = core latency + 1.
- ERR: terminal until rst. in_ready=0, out_valid=0, core_drdy_i=0, core outputs frozen.
- core_drdy_o outside WAIT is ignored with no state change.
- core_plaintext/core_key/core_p_det/core_random_vect are constant from START through the end of WAIT.
- seed_valid:
  - In REFILL or IDLE: load LFSR (0 maps to SEED_DEFAULT), restart REFILL at k=0; IDLE drops in_ready the same cycle.
  - If in_valid & in_ready and seed_valid coincide in IDLE: the seed wins and the block is not accepted (in_ready is combinationally 0 when seed_valid=1).
  - Ignored in START, WAIT, HOLD_OUT, ERR.
- Asynchronous rst mid-operation returns everything to reset values; any in-flight block is discarded.
- busy = (state != IDLE).

Decomposition:
- types package additions: RAND_WORDS=23, CLM_LFSR_TAPS, host state enum host_state_t.
- Sub-module clm_rand_filler: LFSR, fill counter, 23-word register, seed load, done flag. The controller FSM instantiates it.

Test Plan:
- Reset then idle: in_ready rises at cycle 23 after reset release. core_random_vect[0] = low W bits of SEED_DEFAULT after one LFSR step.
- Real core (d=4), plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f (core layout) -> out_ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; core_drdy_i high exactly 1 cycle.
- Behavioral core model with latency 40, out_ready held low 10 cycles: out_valid and out_ciphertext stable throughout; core inputs unchanged during WAIT; next in_ready 24 cycles after out_ready.
- Model never raises drdy_o, TIMEOUT_CYCLES=16: timeout_err=1 sixteen cycles after START; in_ready stays 0; only rst clears it.
- seed_valid with seed=0 coinciding with in_valid in IDLE: block not accepted, LFSR=SEED_DEFAULT, in_ready returns 23 cycles later.
- Spurious core_drdy_o in IDLE and HOLD_OUT: no state or output change. rst asserted mid-WAIT: all outputs return to reset values the same cycle.
